bus_arbiter_hrd: RTL and testbench
==================================

Name: bus_arbiter_hrd

Overview:
- Two-master, one-slave arbiter for the physical memory bus: the responder/grant side of the req/gnt/hrd handshake that the paging MMU initiates.
- Master 0 is the CPU/MMU port (low priority, preemptible via hrd). Master 1 is the hard-priority port (DMA/debug).
- Muxes address, data, we and rd to the slave. Returns spo and ready to the owner only.
- Drains abandoned slave accesses before handing the bus over.

Parameters:
- DRAIN_MAX, 255: maximum cycles to wait for a stale slave ready before giving up.
- HRD_TIMEOUT, 1024: cycles m0_hrd may stay high without m0 releasing before err_hrd is set.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  master 0 bus request
- m0_gnt  out  1  master 0 grant
- m0_hrd  out  1  hard request pending; master 0 must drop m0_req
- m0_a, m0_d  in  32  address / write data
- m0_we, m0_rd  in  1  write / read strobe
- m0_spo  out  32  read data
- m0_ready  out  1  access complete
- m1_req, m1_gnt, m1_a, m1_d, m1_we, m1_rd, m1_spo, m1_ready: same as m0 (master 1 has no hrd)
- s_a, s_d  out  32  slave address / write data
- s_we, s_rd  out  1  slave strobes
- s_spo  in  32  slave read data
- s_ready  in  1  slave completion
- owner  out  2  0 idle, 1 m0, 2 m1, 3 drain
- err_drain  out  1  sticky: drain timed out
- err_hrd  out  1  sticky: m0 ignored hrd past HRD_TIMEOUT

Behaviour:
- Reset (async assert, sync release): state IDLE, inflight 0, counters 0, errs 0, prev_owner m0. All outputs 0 during reset.
- States: IDLE, OWN0, OWN1, DRAIN (registered, 2 bits, encoded on owner).
- Grants are combinational: mx_gnt = (state==OWNx) & mx_req. Dropping req removes gnt in the same cycle.
- m0_hrd = (state==OWN0) & m1_req (combinational). Master 0 drops req in the same cycle.
- Slave mux: when mx_gnt is high, s_a/s_d come from master x and s_we = mx_we, s_rd = mx_rd. Otherwise all slave outputs are 0.
- m0_spo and m1_spo are both driven by s_spo. mx_ready = s_ready & mx_gnt.
- inflight register:
  - outside DRAIN: inflight <= (s_rd | s_we) & !s_ready.
  - in DRAIN: inflight <= inflight & !s_ready.
- Next-owner selection sel(prev):
  - m1_req & m0_req: pick m0 if prev==m1, else m1. This is anti-starvation.
  - otherwise pick whichever master requests; IDLE if neither does.
- IDLE: go to sel(prev_owner). Grant latency is 1 cycle after req is seen.
- OWNx while mx_req is high: stay.
- OWNx with mx_req low: set prev_owner=x.
  - If inflight & !s_ready, go to DRAIN.
  - Otherwise go to sel(x).
  - A same-cycle s_ready completes the stale access and is discarded, since gnt is low.
- DRAIN: count cycles.
  - On s_ready, go to sel(prev_owner).
  - When the count reaches DRAIN_MAX, set err_drain and go to sel(prev_owner).
  - Counter clears on DRAIN exit.
- hrd counter: increments while m0_hrd=1 and clears when it is 0. At HRD_TIMEOUT, set err_hrd and saturate. There is no forced preemption.
- Master 1 is never preempted. Master 1 requests while in DRAIN wait for drain exit.
- Counter widths are $clog2(param+1). Counters saturate; they never wrap.
- Reset mid-transfer: the bus is released immediately and inflight is forgotten. Slave reset is a system concern.

Decomposition:
- Shared package: state encodings (IDLE=0, OWN0=1, OWN1=2, DRAIN=3) and master index constants.
- One natural sub-module, sat_counter (enable, clear, saturate-at-max, hit flag). Instantiate it twice: drain timer and hrd watchdog.

Test Plan:
- Idle, m0_req=1, m0_rd=1, m0_a=32'h1000, s_ready 2 cycles later with s_spo=32'hDEADBEEF -> m0_gnt 1 cycle after req, s_a=32'h1000, m0_spo=32'hDEADBEEF with m0_ready, m1_ready=0.
- m0 owns, m1_req rises -> m0_hrd=1 same cycle; m0 drops req with no inflight -> owner=2 next cycle, m1_gnt=1.
- m0 rd issued, no ready, m0 drops req on hrd -> owner=3; s_ready 5 cycles later is not seen on m0_ready or m1_ready -> owner=2 next cycle.
- DRAIN_MAX=8, slave never readies -> err_drain=1 after 8 drain cycles, bus goes to m1, err_drain stays 1 until rst_n.
- Both request continuously, alternating releases -> grants alternate m1, m0, m1; m0 is never starved.
- HRD_TIMEOUT=16, m0 holds req with m1 requesting -> err_hrd=1 at cycle 16, m0 keeps gnt; rst_n low mid-access -> gnt, s_rd and owner are 0 immediately.

Source files
------------

// File: rtl/bus_arbiter_hrd_pkg.sv
// Shared encodings for the two-master physical bus arbiter.
// Owner/state codes double as the externally visible owner field.
// Holds the next-owner selection rule used from IDLE, release and drain exit.
package bus_arbiter_hrd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // When both masters want the bus, the one that did not own it last wins,
    // so master 0 cannot be starved by a continuously requesting master 1.
    function automatic state_t sel_next(input logic prev_m1, input logic r0, input logic r1);
        if (r0 && r1) return prev_m1 ? ST_OWN0 : ST_OWN1;
        if (r1)       return ST_OWN1;
        if (r0)       return ST_OWN0;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/bus_arbiter_hrd_sat.sv
// Saturating cycle counter with a hit flag for the cycle the count reaches MAX.
// Latency: hit is combinational on the current count and enable.
// Backpressure: none; clear has priority over enable, the count never wraps.
module sat_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam int            W    = $clog2(MAX + 1);
    localparam logic [W-1:0]  TOP  = W'(MAX);
    localparam logic [W-1:0]  LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    // Count enabled cycles, holding at MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != TOP) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High on the enabled cycle that brings the count to MAX, and while held there.
    assign hit = en & (cnt >= LAST);

endmodule

// File: rtl/bus_arbiter_hrd.sv
// Two-master / one-slave bus arbiter with hard-request (hrd) preemption hint to master 0.
// Latency: grant one cycle after request is seen in IDLE; grant/hrd/slave mux are combinational.
// Backpressure: a master holds the bus while req is high; abandoned slave accesses are drained first.
module bus_arbiter_hrd
    import bus_arbiter_hrd_pkg::*;
#(
    parameter int DRAIN_MAX   = 255,
    parameter int HRD_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    output logic        m0_gnt,
    output logic        m0_hrd,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic        m1_req,
    output logic        m1_gnt,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  owner,
    output logic        err_drain,
    output logic        err_hrd
);

    state_t state;
    logic   prev_m1;
    logic   inflight;
    logic   in_drain;
    logic   drain_hit;
    logic   drain_exit;
    logic   hrd_hit;

    assign owner    = state;
    assign in_drain = (state == ST_DRAIN);

    assign m0_gnt = (state == ST_OWN0) & m0_req;
    assign m1_gnt = (state == ST_OWN1) & m1_req;
    assign m0_hrd = (state == ST_OWN0) & m1_req;

    // Read data goes to both masters; ready qualifies which one it is for.
    assign m0_spo   = s_spo;
    assign m1_spo   = s_spo;
    assign m0_ready = s_ready & m0_gnt;
    assign m1_ready = s_ready & m1_gnt;

    // Route the granted master onto the slave bus; park everything at zero otherwise.
    always_comb begin
        s_a  = '0;
        s_d  = '0;
        s_we = 1'b0;
        s_rd = 1'b0;
        if (m0_gnt) begin
            s_a  = m0_a;
            s_d  = m0_d;
            s_we = m0_we;
            s_rd = m0_rd;
        end else if (m1_gnt) begin
            s_a  = m1_a;
            s_d  = m1_d;
            s_we = m1_we;
            s_rd = m1_rd;
        end
    end

    assign drain_exit = in_drain & (s_ready | drain_hit);

    sat_counter #(.MAX(DRAIN_MAX)) u_drain_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_drain),
        .clr   (drain_exit),
        .hit   (drain_hit)
    );

    // Watchdog only flags a master 0 that ignores hrd; it never forces the bus away.
    sat_counter #(.MAX(HRD_TIMEOUT)) u_hrd_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (m0_hrd),
        .clr   (~m0_hrd),
        .hit   (hrd_hit)
    );

    // Ownership FSM, outstanding-access tracking and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prev_m1   <= MST_M0;
            inflight  <= 1'b0;
            err_drain <= 1'b0;
            err_hrd   <= 1'b0;
        end else begin
            if (in_drain) inflight <= inflight & ~s_ready;
            else          inflight <= (s_rd | s_we) & ~s_ready;

            if (hrd_hit) err_hrd <= 1'b1;

            case (state)
                ST_IDLE: state <= sel_next(prev_m1, m0_req, m1_req);
                ST_OWN0: begin
                    if (!m0_req) begin
                        prev_m1 <= MST_M0;
                        // A ready arriving as req drops retires the stale access here.
                        if (inflight && !s_ready) state <= ST_DRAIN;
                        else                      state <= sel_next(MST_M0, m0_req, m1_req);
                    end
                end
                ST_OWN1: begin
                    if (!m1_req) begin
                        prev_m1 <= MST_M1;
                        if (inflight && !s_ready) state <= ST_DRAIN;
                        else                      state <= sel_next(MST_M1, m0_req, m1_req);
                    end
                end
                ST_DRAIN: begin
                    if (s_ready) begin
                        state <= sel_next(prev_m1, m0_req, m1_req);
                    end else if (drain_hit) begin
                        err_drain <= 1'b1;
                        state     <= sel_next(prev_m1, m0_req, m1_req);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_hrd.sv
// Scoreboard bench for bus_arbiter_hrd: directed scenarios followed by random traffic.
// The stimulus thread predicts each cycle's outputs from an owner-level model and queues them;
// a negedge monitor pops and compares, and matches every ready against queued completions.
module tb_bus_arbiter_hrd;

    localparam int DM = 8;
    localparam int HT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_rd, m1_req, m1_we, m1_rd, s_ready;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
    logic        m0_gnt, m0_hrd, m0_ready, m1_gnt, m1_ready;
    logic [31:0] m0_spo, m1_spo, s_a, s_d;
    logic        s_we, s_rd, err_drain, err_hrd;
    logic [1:0]  owner;

    bus_arbiter_hrd #(.DRAIN_MAX(DM), .HRD_TIMEOUT(HT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_hrd(m0_hrd), .m0_a(m0_a), .m0_d(m0_d),
        .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_a(m1_a), .m1_d(m1_d),
        .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .owner(owner), .err_drain(err_drain), .err_hrd(err_hrd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        bit          g0, g1, hrd, r0, r1, we, rd, ed, eh;
        logic [31:0] a, d;
    } exp_t;

    typedef struct {
        bit          mst;
        logic [31:0] data;
    } cpl_t;

    exp_t eq[$];
    cpl_t cq[$];
    int   checks = 0;
    int   errors = 0;

    // Owner-level reference: 0 idle, 1 master 0, 2 master 1, 3 draining.
    int m_owner, m_prev, m_dcnt, m_hcnt;
    bit m_inflight, m_err_d, m_err_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pick(input int prev, input logic r0, input logic r1);
        if (r0 && r1) return (prev == 2) ? 1 : 2;
        if (r1) return 2;
        if (r0) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_prev = 1; m_dcnt = 0; m_hcnt = 0;
        m_inflight = 0; m_err_d = 0; m_err_h = 0;
    endtask

    task automatic model_update(input exp_t e);
        int old   = m_owner;
        int nxt   = m_owner;
        bit stale = m_inflight && !s_ready;
        if (e.hrd) begin
            if (m_hcnt < HT) m_hcnt++;
            if (m_hcnt == HT) m_err_h = 1;
        end else begin
            m_hcnt = 0;
        end
        if (old == 0) begin
            nxt = pick(m_prev, m0_req, m1_req);
        end else if (old == 1 || old == 2) begin
            if (!((old == 1) ? m0_req : m1_req)) begin
                m_prev = old;
                nxt = stale ? 3 : pick(old, m0_req, m1_req);
            end
        end else begin
            if (s_ready) begin
                nxt = pick(m_prev, m0_req, m1_req);
            end else if (m_dcnt + 1 == DM) begin
                m_err_d = 1;
                nxt = pick(m_prev, m0_req, m1_req);
            end
            m_dcnt = (nxt == 3) ? m_dcnt + 1 : 0;
        end
        m_inflight = (old == 3) ? stale : ((e.rd || e.we) && !s_ready);
        m_owner = nxt;
    endtask

    // One clock cycle: predict outputs for current inputs, queue them, then advance the model.
    task automatic step();
        exp_t e;
        if (!rst_n) model_reset();
        e.owner = m_owner;
        e.g0  = (m_owner == 1) && m0_req;
        e.g1  = (m_owner == 2) && m1_req;
        e.hrd = (m_owner == 1) && m1_req;
        e.a   = e.g0 ? m0_a  : (e.g1 ? m1_a  : 32'h0);
        e.d   = e.g0 ? m0_d  : (e.g1 ? m1_d  : 32'h0);
        e.we  = e.g0 ? m0_we : (e.g1 ? m1_we : 1'b0);
        e.rd  = e.g0 ? m0_rd : (e.g1 ? m1_rd : 1'b0);
        e.r0  = s_ready && e.g0;
        e.r1  = s_ready && e.g1;
        e.ed  = m_err_d;
        e.eh  = m_err_h;
        eq.push_back(e);
        if (e.r0 || e.r1) cq.push_back('{mst: e.r1, data: s_spo});
        @(posedge clk);
        if (rst_n) model_update(e);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_rd = 0; m0_a = '0; m0_d = '0;
        m1_req = 0; m1_we = 0; m1_rd = 0; m1_a = '0; m1_d = '0;
        s_ready = 0; s_spo = '0;
    endtask

    // Monitor: compare each queued cycle expectation and every completion the DUT presents.
    always @(negedge clk) begin
        if (eq.size() > 0) begin
            exp_t e;
            e = eq.pop_front();
            chk("owner", 32'(owner), 32'(e.owner));
            chk("gnt_hrd_ready", {27'h0, m0_gnt, m1_gnt, m0_hrd, m0_ready, m1_ready},
                {27'h0, e.g0, e.g1, e.hrd, e.r0, e.r1});
            chk("s_a", s_a, e.a);
            chk("s_d", s_d, e.d);
            chk("s_strobes", {30'h0, s_we, s_rd}, {30'h0, e.we, e.rd});
            chk("err_flags", {30'h0, err_drain, err_hrd}, {30'h0, e.ed, e.eh});
        end
        if (m0_ready || m1_ready) begin
            if (cq.size() == 0) begin
                chk("unexpected_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
            end else begin
                cpl_t c;
                c = cq.pop_front();
                chk("cpl_master", {30'h0, m1_ready, m0_ready}, c.mst ? 32'h2 : 32'h1);
                chk("cpl_data", c.mst ? m1_spo : m0_spo, c.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int old;
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;

        // Reset state
        step(); step();
        chk("reset_owner", 32'(owner), 32'h0);
        chk("reset_outs", {28'h0, m0_gnt, m1_gnt, s_rd, err_drain}, 32'h0);
        rst_n = 1;
        step();

        // Master 0 read, slave answers two cycles after the grant
        m0_req = 1; m0_rd = 1; m0_a = 32'h1000;
        step(); step(); step();
        s_ready = 1; s_spo = 32'hDEADBEEF;
        step();
        s_ready = 0; m0_rd = 0;
        step();

        // Master 1 asks: hrd, master 0 releases cleanly, master 1 gets the bus
        m1_req = 1;
        step();
        m0_req = 0;
        step();
        chk("handover_owner", 32'(owner), 32'h2);
        step();

        // Abandoned read: drain, late ready hidden from both masters, then master 1
        m1_req = 0; m0_req = 1; m0_rd = 1; m0_a = 32'h2000;
        step(); step();
        m1_req = 1;
        step();
        m0_req = 0; m0_rd = 0;
        step();
        chk("drain_owner", 32'(owner), 32'h3);
        step(); step(); step(); step();
        s_ready = 1; s_spo = 32'hCAFEF00D;
        step();
        s_ready = 0;
        chk("post_drain_owner", 32'(owner), 32'h2);
        step();

        // Drain timeout: slave never answers
        m1_req = 0; m0_req = 1; m0_rd = 1; m0_a = 32'h3000;
        step(); step();
        m1_req = 1; m0_req = 0; m0_rd = 0;
        step();
        for (int i = 0; i < DM; i++) step();
        chk("drain_timeout_owner", 32'(owner), 32'h2);
        chk("err_drain_set", 32'(err_drain), 32'h1);
        step(); step(); step();
        chk("err_drain_sticky", 32'(err_drain), 32'h1);

        // Both request; owners take turns releasing
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            step(); step();
            old = m_owner;
            if (old == 1) m0_req = 0;
            else if (old == 2) m1_req = 0;
            step();
            m0_req = 1; m1_req = 1;
            step();
            chk("alternate_owner", 32'(owner), (old == 1) ? 32'h2 : 32'h1);
        end

        // hrd watchdog, then reset in the middle of an access
        rst_n = 0;
        idle_inputs();
        step();
        rst_n = 1;
        step();
        chk("err_drain_cleared", 32'(err_drain), 32'h0);
        m0_req = 1; m0_rd = 1; m0_a = 32'h4000;
        step();
        m1_req = 1;
        for (int i = 0; i < HT + 1; i++) step();
        chk("err_hrd_set", 32'(err_hrd), 32'h1);
        chk("m0_keeps_gnt", 32'(m0_gnt), 32'h1);
        rst_n = 0;
        #1;
        chk("async_reset_bus", {29'h0, m0_gnt, s_rd, 1'b0}, 32'h0);
        chk("async_reset_owner", 32'(owner), 32'h0);
        step();
        rst_n = 1;
        idle_inputs();
        step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) m0_req = ~m0_req;
            if ($urandom_range(5) == 0) m1_req = ~m1_req;
            if (m_owner == 1 && m1_req && $urandom_range(1) == 1) m0_req = 0;
            m0_rd = 1'($urandom_range(1));
            m0_we = ($urandom_range(3) == 0);
            m0_a = $urandom; m0_d = $urandom;
            m1_rd = 1'($urandom_range(1));
            m1_we = ($urandom_range(3) == 0);
            m1_a = $urandom; m1_d = $urandom;
            s_ready = ($urandom_range(2) == 0);
            s_spo = $urandom;
            step();
        end

        idle_inputs();
        step(); step();
        @(negedge clk); #1;
        chk("scoreboard_empty", 32'(eq.size() + cq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
